// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter and bus-request sequencer.
// Raises HRQ on an effective request, grants one channel on HLDA and holds it until xferDone or abort.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CS_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              dreqSenseLow,
  input  logic              dackSenseHigh,
  input  logic              rotatePriority,
  input  logic              HLDA,
  input  logic              xferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [1:0]        grantChannel
);

  localparam int PTR_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_CH-1:0]  eff_req;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   arb_base;
  logic [PTR_W-1:0]   arb_winner;
  logic               arb_found;
  logic               grant_take;
  logic [NUM_CH-1:0]  dack_act;

  assign eff_req    = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg;
  assign grant_take = (state == REQ) && (eff_req != '0) && HLDA;
  assign arb_base   = rotatePriority ? ptr : '0;

  // Search starts at the priority base and wraps; fixed mode is the base-0 case.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand       = '0;
    arb_found  = 1'b0;
    arb_winner = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = arb_base + PTR_W'(k);
      if (!arb_found && eff_req[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (CS_N && (eff_req != '0)) state_nxt = REQ;
      REQ: begin
        if (eff_req == '0) state_nxt = IDLE;
        else if (HLDA)     state_nxt = GRANT;
      end
      GRANT:   if (xferDone || !HLDA) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer advances only on a completed transfer, never on a CPU abort.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      winner <= '0;
      ptr    <= '0;
    end else begin
      if (grant_take) winner <= arb_winner;
      if (!rotatePriority)                  ptr <= '0;
      else if (state == GRANT && xferDone)  ptr <= winner + PTR_W'(1);
    end
  end

  always_comb begin
    HRQ          = (state == REQ) || (state == GRANT);
    grantValid   = (state == GRANT);
    grantChannel = winner;
    dack_act     = '0;
    if (state == GRANT) dack_act[winner] = 1'b1;
    DACK = dackSenseHigh ? dack_act : ~dack_act;
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter: driver pushes model predictions, monitor pops and compares.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET_N;
  logic       CS_N;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       dreqSenseLow;
  logic       dackSenseHigh;
  logic       rotatePriority;
  logic       HLDA;
  logic       xferDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .DREQ(DREQ), .maskReg(maskReg),
    .dreqSenseLow(dreqSenseLow), .dackSenseHigh(dackSenseHigh),
    .rotatePriority(rotatePriority), .HLDA(HLDA), .xferDone(xferDone),
    .HRQ(HRQ), .DACK(DACK), .grantValid(grantValid), .grantChannel(grantChannel)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       hrq;
    logic       gv;
    logic [1:0] gch;
    logic [3:0] dack;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: bus-holding status as flags, service order by modular search.
  bit m_req, m_srv, m_ret;
  int m_win, m_ptr;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] eff, input int base);
    for (int k = 0; k < 4; k++) begin
      if (eff[(base + k) % 4]) return (base + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_req = 0; m_srv = 0; m_ret = 0; m_win = 0; m_ptr = 0;
  endtask

  // Drive inputs for the next edge, predict the state after it, then advance to 2 ns past that edge.
  task automatic step(input logic [3:0] dreq, input logic [3:0] mask, input logic cs_n,
                      input logic sl, input logic sh, input logic rot,
                      input logic hlda, input logic xd);
    logic [3:0] eff;
    logic [3:0] act;
    exp_t       e;
    DREQ = dreq; maskReg = mask; CS_N = cs_n; dreqSenseLow = sl;
    dackSenseHigh = sh; rotatePriority = rot; HLDA = hlda; xferDone = xd;
    for (int i = 0; i < 4; i++) eff[i] = (dreq[i] != sl) && !mask[i];
    if (m_ret) begin
      m_ret = 0;
    end else if (m_srv) begin
      if (xd || !hlda) begin
        m_srv = 0; m_ret = 1;
        if (xd && rot) m_ptr = (m_win + 1) % 4;
      end
    end else if (m_req) begin
      if (eff == 4'b0000) m_req = 0;
      else if (hlda) begin
        m_win = pick(eff, rot ? m_ptr : 0);
        m_req = 0; m_srv = 1;
      end
    end else if (cs_n && eff != 4'b0000) begin
      m_req = 1;
    end
    if (!rot) m_ptr = 0;
    act    = m_srv ? 4'(1 << m_win) : 4'b0000;
    e.hrq  = m_req || m_srv;
    e.gv   = m_srv;
    e.gch  = 2'(m_win);
    e.dack = sh ? act : ~act;
    sb_q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("hrq", 4'(HRQ), 4'(e.hrq));
        check("grant_valid", 4'(grantValid), 4'(e.gv));
        check("dack", DACK, e.dack);
        if (e.gv) check("grant_channel", 4'(grantChannel), 4'(e.gch));
      end
    end
  end

  initial begin
    RESET_N = 1'b0; CS_N = 1'b1; DREQ = '0; maskReg = '0; dreqSenseLow = 1'b0;
    dackSenseHigh = 1'b1; rotatePriority = 1'b0; HLDA = 1'b0; xferDone = 1'b0;
    model_reset();
    #3;
    check("reset_hrq", 4'(HRQ), 4'h0);
    check("reset_grant_valid", 4'(grantValid), 4'h0);
    check("reset_grant_channel", 4'(grantChannel), 4'h0);
    check("reset_dack_high", DACK, 4'h0);
    #10;
    dackSenseHigh = 1'b0;
    #1;
    check("reset_dack_low", DACK, 4'hF);
    dackSenseHigh = 1'b1;
    RESET_N = 1'b1;
    @(posedge CLK);
    #2;

    // Fixed priority: ch1 beats ch2.
    step(4'b0110, 4'b0000, 1, 0, 1, 0, 0, 0);
    step(4'b0110, 4'b0000, 1, 0, 1, 0, 1, 0);
    check("fixed_grant_ch", 4'(grantChannel), 4'h1);
    check("fixed_dack", DACK, 4'b0010);
    step(4'b0110, 4'b0000, 1, 0, 1, 0, 1, 1);
    step(4'b0000, 4'b0000, 1, 0, 1, 0, 0, 0);

    // Rotating: ch1 served, pointer moves to 2, then ch0 beats ch1.
    step(4'b0010, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0010, 4'b0000, 1, 0, 1, 1, 1, 0);
    step(4'b0010, 4'b0000, 1, 0, 1, 1, 1, 1);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 1, 0);
    check("rotate_grant_ch", 4'(grantChannel), 4'h0);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 1, 1);
    step(4'b0000, 4'b0000, 1, 0, 1, 1, 0, 0);

    // Inverted senses.
    step(4'b1110, 4'b0000, 1, 1, 0, 0, 0, 0);
    step(4'b1110, 4'b0000, 1, 1, 0, 0, 1, 0);
    check("lowsense_dack_grant", DACK, 4'b1110);
    step(4'b1110, 4'b0000, 1, 1, 0, 0, 1, 1);
    step(4'b1111, 4'b0000, 1, 1, 0, 0, 0, 0);
    check("lowsense_dack_idle", DACK, 4'b1111);

    // Mask and chip select gating, then withdrawal in REQ.
    step(4'b0001, 4'b0001, 1, 0, 1, 0, 0, 0);
    step(4'b0001, 4'b0001, 1, 0, 1, 0, 1, 0);
    check("masked_hrq", 4'(HRQ), 4'h0);
    step(4'b0001, 4'b0000, 0, 0, 1, 0, 0, 0);
    step(4'b0001, 4'b0000, 0, 0, 1, 0, 0, 0);
    check("cs_hrq", 4'(HRQ), 4'h0);
    step(4'b0001, 4'b0000, 1, 0, 1, 0, 0, 0);
    check("cs_release_hrq", 4'(HRQ), 4'h1);
    step(4'b0000, 4'b0000, 1, 0, 1, 0, 1, 0);
    check("withdraw_hrq", 4'(HRQ), 4'h0);

    // Rotating, ptr=0 -> serve ch0 to move ptr to 1; abort on ch2 must leave ptr at 1.
    step(4'b0001, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0001, 4'b0000, 1, 0, 1, 1, 1, 0);
    step(4'b0001, 4'b0000, 1, 0, 1, 1, 1, 1);
    step(4'b0000, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0100, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0100, 4'b0000, 1, 0, 1, 1, 1, 0);
    step(4'b0100, 4'b0000, 1, 0, 1, 1, 0, 0);
    check("abort_release_hrq", 4'(HRQ), 4'h0);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 1, 0);
    check("abort_ptr_kept", 4'(grantChannel), 4'h1);
    step(4'b0011, 4'b0000, 1, 0, 1, 1, 1, 1);

    // Pointer now 2; reset mid-grant must clear outputs at once and the pointer.
    step(4'b0000, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b1000, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b1000, 4'b0000, 1, 0, 1, 1, 1, 0);
    #1;
    RESET_N = 1'b0;
    #1;
    check("async_reset_hrq", 4'(HRQ), 4'h0);
    check("async_reset_grant_valid", 4'(grantValid), 4'h0);
    check("async_reset_dack", DACK, 4'h0);
    DREQ = '0; HLDA = 1'b0;
    model_reset();
    #1;
    RESET_N = 1'b1;
    @(posedge CLK);
    #2;
    step(4'b0110, 4'b0000, 1, 0, 1, 1, 0, 0);
    step(4'b0110, 4'b0000, 1, 0, 1, 1, 1, 0);
    check("reset_ptr_zero", 4'(grantChannel), 4'h1);
    step(4'b0110, 4'b0000, 1, 0, 1, 1, 1, 1);

    for (int n = 0; n < 3000; n++) begin
      step(4'($urandom),
           4'($urandom) & 4'($urandom) & 4'($urandom),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) != 0),
           1'($urandom),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 2));
    end

    @(posedge CLK);
    #2;
    check("scoreboard_drained", 4'(sb_q.size()), 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel priority and bus-request sequencer for the 4-channel DMA controller.
- Samples channel requests (DREQ), applies mask and polarity, and requests the bus from the CPU (HRQ/HLDA).
- Grants exactly one channel via DACK and holds the grant until the timing-and-control FSM reports the transfer complete.
- Supports fixed priority (channel 0 highest) or rotating priority.

Parameters:
NUM_CH, 4, number of DMA channels. Only 4 is supported; priority pointer is 2 bits.

Ports:
CLK  input  1  system clock; all logic on the rising edge
RESET_N  input  1  asynchronous active-low reset
CS_N  input  1  chip select; low means the CPU is programming registers
DREQ  input  4  channel DMA requests, raw pins
maskReg  input  4  per-channel mask; 1 = channel ignored
dreqSenseLow  input  1  1 = DREQ active-low
dackSenseHigh  input  1  1 = DACK active-high
rotatePriority  input  1  1 = rotating priority, 0 = fixed priority
HLDA  input  1  hold acknowledge from the CPU
xferDone  input  1  single-cycle pulse from timing-and-control; current service finished (EOP or end of transfer)
HRQ  output  1  hold request to the CPU, active-high
DACK  output  4  channel acknowledges, polarity per dackSenseHigh
grantValid  output  1  a channel is currently granted
grantChannel  output  2  index of the granted channel

Behaviour:
- Effective request: effReq[i] = (DREQ[i] XOR dreqSenseLow) AND NOT maskReg[i]. It is combinational, evaluated at each edge.
- Reset values (asynchronous, while RESET_N=0):
  - state=IDLE, HRQ=0, grantValid=0, grantChannel=0.
  - Priority pointer=0.
  - DACK inactive. DACK tracks dackSenseHigh combinationally: 4'b0000 if dackSenseHigh=1, else 4'b1111.
- States are IDLE, REQ, GRANT, RELEASE.
- IDLE:
  - If CS_N=1 and effReq!=0 at an edge, go to REQ; HRQ=1 after that edge. Latency is 1 clock from the sampled request to HRQ.
  - If CS_N=0, no new request is raised.
- REQ (HRQ=1):
  - If effReq==0 at an edge (request withdrawn), go to IDLE; HRQ=0 after that edge.
  - Otherwise, if HLDA=1, arbitrate on the current effReq and latch the winner. Go to GRANT.
  - After the HLDA-sampled edge: DACK[winner] active, grantValid=1, grantChannel=winner.
  - Withdrawal takes precedence over HLDA in the same cycle.
- Arbitration:
  - Fixed mode: lowest-index requesting channel wins.
  - Rotating mode: the channel at the pointer has highest priority, then pointer+1, pointer+2, pointer+3, all mod 4.
- GRANT:
  - HRQ stays 1 and the grant is frozen. Changes to DREQ or maskReg do not alter the current grant.
  - On xferDone=1: DACK inactive, grantValid=0, go to RELEASE. If rotatePriority=1, pointer=(winner+1) mod 4.
  - On HLDA=0 without xferDone (CPU abort): same exit, but the pointer is not updated.
  - xferDone and HLDA=0 in the same cycle: treated as xferDone; rotation applies.
- RELEASE:
  - HRQ=0 for exactly one cycle, then go to IDLE.
  - The bus is always returned between grants, so back-to-back services are separated by at least IDLE→REQ→HLDA.
- Pointer: forced to 0 at any edge where rotatePriority=0.
- Invariants:
  - At most one DACK is active.
  - grantValid=1 only in GRANT.
  - HRQ=1 only in REQ and GRANT.
- Reset mid-operation: all outputs return immediately to their reset values; there is no completion of the pending transfer.

Test Plan:
- Fixed priority, DREQ=4'b0110, mask=0, active-high senses → HRQ=1 one cycle later. After HLDA=1: DACK=4'b0100? No: winner is channel 1, so DACK=4'b0010, grantChannel=1.
- Rotating priority: service ch1 then xferDone; re-request DREQ=4'b0011 → ch1 wins first, then ch0 wins the second arbitration because the pointer is now 2 and ch0 precedes ch1.
- dreqSenseLow=1, dackSenseHigh=0, DREQ=4'b1110 → ch0 requests; granted DACK=4'b1110, idle DACK=4'b1111.
- Mask/CS: maskReg=4'b0001 with DREQ=4'b0001 → HRQ stays 0. CS_N=0 with an unmasked request → HRQ stays 0 until CS_N=1, then rises 1 cycle later.
- Abort and withdrawal:
  - In GRANT on ch2, drop HLDA → DACK inactive next edge, one RELEASE cycle with HRQ=0, pointer unchanged.
  - In REQ, drop DREQ before HLDA → HRQ=0 next edge.
- Assert RESET_N=0 during GRANT → HRQ=0, DACK inactive and grantValid=0 immediately (asynchronously, without waiting for an edge); pointer=0.
